switch_input_port: RTL

SWITCH_INPUT_PORT -- requirements
Module: switch_input_port

---
 rtl/switch_input_port_pkg.sv | 31 +++
 rtl/switch_input_port_debouncer.sv | 73 +++++++
 rtl/switch_input_port.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/switch_input_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : switch_input_port_pkg
// Brief    : Shared types and defaults for the switch input port: control
//            FSM state encoding, default debounce/synchronizer depths and a
//            counter-width helper.
// Revision : 1.0  initial release
// ============================================================================
package switch_input_port_pkg;

  // 10 ms of stability at a 20 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 200_000;

  // Two flops is the minimum safe depth; deeper chains (up to 4) trade
  // latency for MTBF.
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Control FSM: IDLE is released and armed, PRESSED waits for release so a
  // single physical press yields exactly one capture.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } ctrl_state_e;

  // Width of a counter that must reach cycles-1; never narrower than 1 bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage : switch_input_port_pkg
`default_nettype wire

// File: rtl/switch_input_port_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_input_port_debouncer
// Brief    : Synchronizer chain plus stability counter for one asynchronous
//            level. The accepted (stable) level only changes after the
//            synchronized input has differed from it for DEBOUNCE_CYCLES
//            consecutive cycles. A one-cycle event marks every transition
//            from the idle level to the active level.
// Revision : 1.0  initial release
// ============================================================================
module switch_input_port_debouncer
  import switch_input_port_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic active,
  output logic active_evt
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   evt_q, evt_d;
  logic                   din_sync;

  assign din_sync = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchronizer chain, then count how long
  // the synchronized level has disagreed with the accepted level.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    evt_d    = 1'b0;
    if (din_sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      stable_d = ~stable_q;
      evt_d    = (stable_q == IDLE_LEVEL);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; everything resets to the idle (released) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_q    <= '0;
      stable_q <= IDLE_LEVEL;
      evt_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      evt_q    <= evt_d;
    end
  end

  assign active     = stable_q ^ IDLE_LEVEL;
  assign active_evt = evt_q;

endmodule : switch_input_port_debouncer
`default_nettype wire

// File: rtl/switch_input_port.sv
`default_nettype none
// ============================================================================
// Module   : switch_input_port
// Brief    : Slide-switch byte input with an ENTER pushbutton. Each debounced
//            press latches the synchronized switch byte into a one-deep
//            holding register that the computer drains with rd_ack.
//            Optional build macro SWITCH_INPUT_OVERRUN_EN adds an overrun
//            flag reporting presses discarded while a byte was still unread.
// Revision : 1.0  initial release
// ============================================================================
module switch_input_port
  import switch_input_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw_in,
  input  logic       btn_enter_n,
  output logic [7:0] in_val,
  output logic       in_valid,
  input  logic       rd_ack,
  output logic       btn_state
`ifdef SWITCH_INPUT_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  logic [SYNC_STAGES-1:0][7:0] sw_sync_q, sw_sync_d;
  logic [7:0]  sw_sync;
  logic        btn_level;
  logic        press_evt;
  ctrl_state_e state_q, state_d;
  logic [7:0]  in_val_q, in_val_d;
  logic        in_valid_q, in_valid_d;
  logic        capture;
  logic        discard;

  // Button: synchronizer, debounce counter and press event.
  switch_input_port_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES),
    .IDLE_LEVEL      (1'b1)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .din        (btn_enter_n),
    .active     (btn_level),
    .active_evt (press_evt)
  );

  // Switch byte: synchronizer chain only; switches are sampled on a press,
  // long after they have settled, so no debouncing is needed.
  always_comb begin
    sw_sync_d[0] = sw_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sw_sync_d[i] = sw_sync_q[i-1];
    end
  end

  // Switch synchronizer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync_q <= '0;
    end else begin
      sw_sync_q <= sw_sync_d;
    end
  end

  assign sw_sync = sw_sync_q[SYNC_STAGES-1];

  // Press FSM and holding register: a press in IDLE captures the byte unless
  // an unread byte is still held and not being acknowledged this cycle.
  always_comb begin
    state_d    = state_q;
    in_val_d   = in_val_q;
    in_valid_d = in_valid_q;
    capture    = 1'b0;
    discard    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_evt) begin
          state_d = ST_PRESSED;
          if (!in_valid_q || rd_ack) begin
            capture = 1'b1;
          end else begin
            discard = 1'b1;
          end
        end
      end
      ST_PRESSED: begin
        if (!btn_level) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (capture) begin
      in_val_d   = sw_sync;
      in_valid_d = 1'b1;
    end else if (rd_ack && in_valid_q) begin
      in_valid_d = 1'b0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      in_val_q   <= 8'h00;
      in_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_val_q   <= in_val_d;
      in_valid_q <= in_valid_d;
    end
  end

  assign in_val    = in_val_q;
  assign in_valid  = in_valid_q;
  assign btn_state = btn_level;

`ifdef SWITCH_INPUT_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky overrun flag: set by a discarded press, cleared by any rd_ack.
  always_comb begin
    overrun_d = overrun_q;
    if (discard) begin
      overrun_d = 1'b1;
    end else if (rd_ack) begin
      overrun_d = 1'b0;
    end
  end

  // Overrun register.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  // Discards are silent in this build.
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule : switch_input_port
`default_nettype wire
